// File: rtl/serial_link_pkg.sv
// -----------------------------------------------------------------------------
// serial_link_pkg
// Shared definitions for both ends of the shift-register serial link.
// Holds the 2-bit sel encoding, the receiver FSM state encodings and a small
// decode helper, so transmitter and receiver agree on one encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package serial_link_pkg;

   typedef logic [1:0] sel_t;

   // Operation select shared with the transmitter
   localparam sel_t SEL_CLEAR = 2'b00;  // abort frame, clear overrun
   localparam sel_t SEL_LSB   = 2'b01;  // receive, least significant bit first
   localparam sel_t SEL_MSB   = 2'b10;  // receive, most significant bit first
   localparam sel_t SEL_HOLD  = 2'b11;  // freeze everything except ack

   // Receiver FSM states
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   // True for the two select codes that accept serial bits
   function automatic logic sel_is_rx(input sel_t sel);
      return (sel == SEL_LSB) || (sel == SEL_MSB);
   endfunction

endpackage : serial_link_pkg

// File: rtl/rx_bit_counter.sv
// -----------------------------------------------------------------------------
// rx_bit_counter
// Counts bits taken within the current frame. Wraps to zero on the last bit
// of a word and flags that bit so the caller can complete the word on the
// same edge.
// Ports:
//   clock   in   rising-edge clock
//   reset   in   synchronous active-low reset
//   clr_i   in   force count to zero (frame abort)
//   en_i    in   a bit is taken this cycle
//   term_o  out  this enabled bit is the WIDTH-th bit of the frame
// -----------------------------------------------------------------------------
module rx_bit_counter
   import serial_link_pkg::*;
#(
   parameter int WIDTH = 16,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic clock,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic term_o
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign term_o = en_i && (cnt_q == CNT_LAST);

   // Next count: clear wins, terminal bit wraps to zero, otherwise count up
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = CNT_ZERO;
      end else if (term_o) begin
         cnt_d = CNT_ZERO;
      end else if (en_i) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt_q <= CNT_ZERO;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : rx_bit_counter

// File: rtl/serial_word_receiver.sv
// -----------------------------------------------------------------------------
// serial_word_receiver
// Receive end of the shift-register serial link. Takes one bit per cycle in
// which ser_valid is high and sel selects a receive mode, reassembles WIDTH-bit
// words LSB-first or MSB-first, and presents each finished word on a registered
// bus with a one-cycle out_valid pulse and a pending/ack handshake.
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous active-low reset
//   ser_in     in   serial data bit
//   ser_valid  in   ser_in is valid this cycle
//   sel        in   00 clear/abort, 01 LSB-first, 10 MSB-first, 11 hold
//   out_ack    in   consumer accepts the word, clears pending
//   out        out  last completed word
//   out_valid  out  pulse: out was updated by the previous edge
//   pending    out  a word is held and not yet acknowledged
//   busy       out  frame in progress
//   overrun    out  sticky: word completed while the previous one was pending
// -----------------------------------------------------------------------------
module serial_word_receiver
   import serial_link_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ser_in,
   input  logic             ser_valid,
   input  logic [1:0]       sel,
   input  logic             out_ack,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic             pending,
   output logic             busy,
   output logic             overrun
);

   generate
      if (WIDTH < 2) begin : g_width_check
         $error("serial_word_receiver: WIDTH must be at least 2");
      end
   endgenerate

   localparam logic [WIDTH-1:0] WORD_ZERO = {WIDTH{1'b0}};

   logic [0:0]       state_q,   state_d;
   logic             dir_q,     dir_d;      // 1 = MSB-first
   logic [WIDTH-1:0] shreg_q,   shreg_d;
   logic [WIDTH-1:0] out_q,     out_d;
   logic             out_valid_q, out_valid_d;
   logic             pending_q, pending_d;
   logic             overrun_q, overrun_d;

   logic             take_s;
   logic             clr_s;
   logic             done_s;
   logic             dir_s;
   logic [WIDTH-1:0] base_s;
   logic [WIDTH-1:0] shifted_s;

   assign take_s = sel_is_rx(sel) && ser_valid;
   assign clr_s  = (sel == SEL_CLEAR);

   // The first bit of a frame latches the direction and starts from an empty
   // register; later bits use the latched direction so a mid-frame switch
   // between the two receive codes has no effect.
   assign dir_s  = (state_q == ST_IDLE) ? (sel == SEL_MSB) : dir_q;
   assign base_s = (state_q == ST_IDLE) ? WORD_ZERO : shreg_q;

   // Shift the incoming bit into the frame register in the selected order
   always_comb begin
      shifted_s = base_s;
      if (dir_s) begin
         shifted_s = {base_s[WIDTH-2:0], ser_in};
      end else begin
         shifted_s = {ser_in, base_s[WIDTH-1:1]};
      end
   end

   rx_bit_counter #(
      .WIDTH (WIDTH)
   ) u_bit_counter (
      .clock  (clock),
      .reset  (reset),
      .clr_i  (clr_s),
      .en_i   (take_s),
      .term_o (done_s)
   );

   // Next-state logic for FSM, frame register and output handshake registers
   always_comb begin
      state_d     = state_q;
      dir_d       = dir_q;
      shreg_d     = shreg_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      pending_d   = pending_q;
      overrun_d   = overrun_q;

      // Ack is honoured in every mode; a completion below re-arms pending
      if (out_ack) begin
         pending_d = 1'b0;
      end else begin
         pending_d = pending_q;
      end

      case (sel)
         SEL_CLEAR: begin
            state_d   = ST_IDLE;
            shreg_d   = WORD_ZERO;
            overrun_d = 1'b0;
         end
         SEL_LSB, SEL_MSB: begin
            if (ser_valid) begin
               dir_d   = dir_s;
               shreg_d = shifted_s;
               if (done_s) begin
                  state_d     = ST_IDLE;
                  out_d       = shifted_s;
                  out_valid_d = 1'b1;
                  pending_d   = 1'b1;
                  // Only an unacknowledged previous word is lost
                  if (pending_q && !out_ack) begin
                     overrun_d = 1'b1;
                  end else begin
                     overrun_d = overrun_q;
                  end
               end else begin
                  state_d = ST_SHIFT;
               end
            end else begin
               state_d = state_q;
            end
         end
         SEL_HOLD: begin
            state_d = state_q;
         end
         default: begin
            state_d = state_q;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         dir_q       <= 1'b0;
         shreg_q     <= WORD_ZERO;
         out_q       <= WORD_ZERO;
         out_valid_q <= 1'b0;
         pending_q   <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         dir_q       <= dir_d;
         shreg_q     <= shreg_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         pending_q   <= pending_d;
         overrun_q   <= overrun_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign pending   = pending_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q == ST_SHIFT);

endmodule : serial_word_receiver

// File: tb/tb_serial_word_receiver.sv
// -----------------------------------------------------------------------------
// tb_serial_word_receiver
// Directed bench for serial_word_receiver. A word-level model tracks which bit
// position each received bit lands in and the handshake flags; DUT outputs are
// compared to it on every falling edge, plus literal expectations per scenario.
// -----------------------------------------------------------------------------
module tb_serial_word_receiver;
   import serial_link_pkg::*;

   localparam int W = 16;

   logic         clock     = 1'b0;
   logic         reset     = 1'b0;
   logic         ser_in    = 1'b0;
   logic         ser_valid = 1'b0;
   logic [1:0]   sel       = 2'b00;
   logic         out_ack   = 1'b0;
   logic [W-1:0] out;
   logic         out_valid;
   logic         pending;
   logic         busy;
   logic         overrun;

   int errors = 0;
   int checks = 0;
   int pulses = 0;

   always #5 clock = ~clock;

   serial_word_receiver #(
      .WIDTH (W)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .ser_in    (ser_in),
      .ser_valid (ser_valid),
      .sel       (sel),
      .out_ack   (out_ack),
      .out       (out),
      .out_valid (out_valid),
      .pending   (pending),
      .busy      (busy),
      .overrun   (overrun)
   );

   // Word-level model: bit k of a frame goes to position k (LSB-first)
   // or W-1-k (MSB-first); handshake flags follow the receive rules.
   logic [W-1:0] m_out     = 16'h0000;
   logic [W-1:0] m_word    = 16'h0000;
   logic         m_valid   = 1'b0;
   logic         m_pending = 1'b0;
   logic         m_overrun = 1'b0;
   logic         m_busy    = 1'b0;
   logic         m_dir     = 1'b0;
   int           m_cnt     = 0;

   always @(posedge clock) begin : model
      logic pend_before;
      if (!reset) begin
         m_out = 16'h0000; m_word = 16'h0000; m_valid = 1'b0; m_pending = 1'b0;
         m_overrun = 1'b0; m_busy = 1'b0; m_dir = 1'b0; m_cnt = 0;
      end else begin
         m_valid     = 1'b0;
         pend_before = m_pending;
         if (out_ack) m_pending = 1'b0;
         if (sel == 2'b00) begin
            m_busy = 1'b0; m_cnt = 0; m_word = 16'h0000; m_overrun = 1'b0;
         end else if (sel != 2'b11 && ser_valid) begin
            if (!m_busy) begin
               m_busy = 1'b1; m_dir = (sel == 2'b10); m_cnt = 0; m_word = 16'h0000;
            end
            if (m_dir) m_word[W-1-m_cnt] = ser_in;
            else       m_word[m_cnt]     = ser_in;
            m_cnt = m_cnt + 1;
            if (m_cnt == W) begin
               m_out = m_word; m_valid = 1'b1; m_pending = 1'b1;
               if (pend_before && !out_ack) m_overrun = 1'b1;
               m_busy = 1'b0; m_cnt = 0;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs, then compare all outputs against the model
   task automatic drive(input logic [1:0] s, input logic v, input logic b, input logic a);
      sel = s; ser_valid = v; ser_in = b; out_ack = a;
      @(negedge clock);
      chk("out",       32'(out),       32'(m_out));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("pending",   32'(pending),   32'(m_pending));
      chk("busy",      32'(busy),      32'(m_busy));
      chk("overrun",   32'(overrun),   32'(m_overrun));
      if (out_valid === 1'b1) pulses++;
   endtask

   task automatic send_word(input logic [1:0] s, input logic [W-1:0] w, input bit gap,
                            input logic ack_last);
      for (int i = 0; i < W; i++) begin
         logic b;
         b = (s == SEL_MSB) ? w[W-1-i] : w[i];
         drive(s, 1'b1, b, (i == W-1) ? ack_last : 1'b0);
         if (gap && i != W-1) drive(s, 1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      logic [W-1:0] w;
      @(negedge clock);

      // Reset held with toggling inputs
      reset = 1'b0;
      for (int i = 0; i < 10; i++) drive(SEL_LSB, 1'(i % 2), 1'((i / 2) % 2), 1'b0);
      chk("rst_out", 32'(out), 32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_pending", 32'(pending), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_overrun", 32'(overrun), 32'h0);
      reset = 1'b1;
      drive(SEL_HOLD, 1'b0, 1'b0, 1'b0);

      // LSB-first 50, contiguous
      pulses = 0;
      send_word(SEL_LSB, 16'd50, 1'b0, 1'b0);
      chk("lsb50_out", 32'(out), 32'd50);
      chk("lsb50_valid", 32'(out_valid), 32'h1);
      chk("lsb50_pending", 32'(pending), 32'h1);
      drive(SEL_HOLD, 1'b0, 1'b0, 1'b0);
      chk("lsb50_valid_drop", 32'(out_valid), 32'h0);
      chk("lsb50_pulses", 32'(pulses), 32'd1);

      // MSB-first 40 with gaps
      drive(SEL_LSB, 1'b0, 1'b0, 1'b1);
      chk("ack_clears", 32'(pending), 32'h0);
      pulses = 0;
      send_word(SEL_MSB, 16'd40, 1'b1, 1'b0);
      chk("msb40_out", 32'(out), 32'd40);
      drive(SEL_HOLD, 1'b0, 1'b0, 1'b0);
      chk("msb40_pulses", 32'(pulses), 32'd1);

      // Partial frame aborted by CLEAR, then 10
      drive(SEL_LSB, 1'b0, 1'b0, 1'b1);
      pulses = 0;
      w = 16'hA5C3;
      for (int i = 0; i < 8; i++) drive(SEL_LSB, 1'b1, w[i], 1'b0);
      chk("partial_busy", 32'(busy), 32'h1);
      drive(SEL_CLEAR, 1'b0, 1'b0, 1'b0);
      chk("clear_busy", 32'(busy), 32'h0);
      send_word(SEL_LSB, 16'd10, 1'b0, 1'b0);
      drive(SEL_HOLD, 1'b0, 1'b0, 1'b0);
      chk("abort_pulses", 32'(pulses), 32'd1);
      chk("abort_out", 32'(out), 32'd10);

      // Overrun: back-to-back words without ack
      drive(SEL_CLEAR, 1'b0, 1'b0, 1'b1);
      send_word(SEL_LSB, 16'd20, 1'b0, 1'b0);
      send_word(SEL_LSB, 16'd50, 1'b0, 1'b0);
      chk("ovr_out", 32'(out), 32'd50);
      chk("ovr_flag", 32'(overrun), 32'h1);
      chk("ovr_pending", 32'(pending), 32'h1);

      // Ack in the completion cycle of the second word
      drive(SEL_CLEAR, 1'b0, 1'b0, 1'b1);
      chk("clear_ovr", 32'(overrun), 32'h0);
      send_word(SEL_LSB, 16'd20, 1'b0, 1'b0);
      send_word(SEL_LSB, 16'd50, 1'b0, 1'b1);
      chk("ack_ovr_flag", 32'(overrun), 32'h0);
      chk("ack_ovr_pending", 32'(pending), 32'h1);
      chk("ack_ovr_out", 32'(out), 32'd50);

      // HOLD mid-frame with garbage bits
      drive(SEL_LSB, 1'b0, 1'b0, 1'b1);
      w = 16'h00FF;
      for (int i = 0; i < 8; i++) drive(SEL_LSB, 1'b1, w[i], 1'b0);
      for (int i = 0; i < 5; i++) drive(SEL_HOLD, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      chk("hold_busy", 32'(busy), 32'h1);
      for (int i = 8; i < W; i++) drive(SEL_LSB, 1'b1, w[i], 1'b0);
      chk("hold_out", 32'(out), 32'h00FF);
      chk("hold_valid", 32'(out_valid), 32'h1);

      // Reset mid-frame discards the partial word and clears out
      for (int i = 0; i < 5; i++) drive(SEL_MSB, 1'b1, 1'b1, 1'b0);
      reset = 1'b0;
      drive(SEL_MSB, 1'b1, 1'b1, 1'b0);
      reset = 1'b1;
      chk("midrst_out", 32'(out), 32'h0);
      chk("midrst_busy", 32'(busy), 32'h0);
      send_word(SEL_MSB, 16'h8001, 1'b0, 1'b0);
      chk("post_rst_out", 32'(out), 32'h8001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_serial_word_receiver
